riscv_core_lsu_ctrl: RTL and testbench

Load/store sequencing controller between the MEM pipeline stage and the data cache port. Accepts one memory op at a time, checks natural alignment, runs the cache request/acknowledge handshake, aligns store data and byte enables, and aligns returned load data before sign- or zero-extension. Returns a registered writeback result and a done pulse, and drives a stall to the pipeline while busy.

---
 rtl/riscv_core_lsu_pkg.sv | 39 +++
 rtl/riscv_core_lsu_ctrl_if.sv | 45 ++++
 rtl/riscv_core_ldextend.sv | 19 +
 rtl/riscv_core_lsu_ctrl.sv | 167 ++++++++++++++++
 tb/tb_riscv_core_lsu_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_lsu_pkg.sv
// rtl/riscv_core_lsu_pkg.sv - shared types, size codes and byte-enable helpers for the LSU controller
package riscv_core_lsu_pkg;
    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_EXC
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [7:0] BE_B = 8'h01;
    localparam logic [7:0] BE_H = 8'h03;
    localparam logic [7:0] BE_W = 8'h0F;
    localparam logic [7:0] BE_D = 8'hFF;

    function automatic logic [7:0] be_base(input logic [1:0] size);
        case (size)
            SIZE_B:  return BE_B;
            SIZE_H:  return BE_H;
            SIZE_W:  return BE_W;
            default: return BE_D;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SIZE_H:  return off[0];
            SIZE_W:  return |off[1:0];
            SIZE_D:  return |off;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/riscv_core_lsu_ctrl_if.sv
// rtl/riscv_core_lsu_ctrl_if.sv - pipeline and data-cache signal bundle of the LSU controller
interface riscv_core_lsu_ctrl_if;
    import riscv_core_lsu_pkg::*;

    logic            i_lsu_valid;
    logic            o_lsu_ready;
    logic            i_lsu_we;
    logic [1:0]      i_lsu_size;
    logic            i_lsu_su_extend;
    logic [XLEN-1:0] i_lsu_addr;
    logic [XLEN-1:0] i_lsu_wdata;
    logic [4:0]      i_lsu_rd;
    logic            i_lsu_kill;
    logic            o_lsu_stall;
    logic            o_dc_req;
    logic            o_dc_we;
    logic [XLEN-1:0] o_dc_addr;
    logic [7:0]      o_dc_be;
    logic [XLEN-1:0] o_dc_wdata;
    logic            i_dc_ack;
    logic [XLEN-1:0] i_dc_rdata;
    logic            o_lsu_done;
    logic            o_lsu_wb_valid;
    logic [4:0]      o_lsu_wb_rd;
    logic [XLEN-1:0] o_lsu_wb_data;
    logic            o_lsu_misalign;
    logic            o_lsu_exc_st;
    logic [XLEN-1:0] o_lsu_badaddr;

    modport slave (
        input  i_lsu_valid, i_lsu_we, i_lsu_size, i_lsu_su_extend, i_lsu_addr,
               i_lsu_wdata, i_lsu_rd, i_lsu_kill, i_dc_ack, i_dc_rdata,
        output o_lsu_ready, o_lsu_stall, o_dc_req, o_dc_we, o_dc_addr, o_dc_be,
               o_dc_wdata, o_lsu_done, o_lsu_wb_valid, o_lsu_wb_rd, o_lsu_wb_data,
               o_lsu_misalign, o_lsu_exc_st, o_lsu_badaddr
    );

    modport master (
        output i_lsu_valid, i_lsu_we, i_lsu_size, i_lsu_su_extend, i_lsu_addr,
               i_lsu_wdata, i_lsu_rd, i_lsu_kill, i_dc_ack, i_dc_rdata,
        input  o_lsu_ready, o_lsu_stall, o_dc_req, o_dc_we, o_dc_addr, o_dc_be,
               o_dc_wdata, o_lsu_done, o_lsu_wb_valid, o_lsu_wb_rd, o_lsu_wb_data,
               o_lsu_misalign, o_lsu_exc_st, o_lsu_badaddr
    );
endinterface

// File: rtl/riscv_core_ldextend.sv
// rtl/riscv_core_ldextend.sv - sign/zero extension of a right-justified load value
module riscv_core_ldextend
    import riscv_core_lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_size,
    input  logic            i_su_extend,
    output logic [XLEN-1:0] o_data
);
    always_comb begin
        o_data = i_data;
        case (i_size)
            SIZE_B:  o_data = {{56{~i_su_extend & i_data[7]}},  i_data[7:0]};
            SIZE_H:  o_data = {{48{~i_su_extend & i_data[15]}}, i_data[15:0]};
            SIZE_W:  o_data = {{32{~i_su_extend & i_data[31]}}, i_data[31:0]};
            default: o_data = i_data;
        endcase
    end
endmodule

// File: rtl/riscv_core_lsu_ctrl.sv
// rtl/riscv_core_lsu_ctrl.sv - single-op load/store sequencer between MEM stage and data cache
module riscv_core_lsu_ctrl
    import riscv_core_lsu_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    riscv_core_lsu_ctrl_if.slave bus
);
    lsu_state_t      state_q, state_d;
    logic            we_q, we_d, su_q, su_d, kill_q, kill_d;
    logic [1:0]      size_q, size_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [4:0]      rd_q, rd_d;
    logic            ready_q, ready_d, dc_req_q, dc_req_d, dc_we_q, dc_we_d;
    logic [XLEN-1:0] dc_addr_q, dc_addr_d, dc_wdata_q, dc_wdata_d;
    logic [7:0]      dc_be_q, dc_be_d;
    logic            done_q, done_d, wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d, badaddr_q, badaddr_d;
    logic            misalign_q, misalign_d, exc_st_q, exc_st_d;
    logic [XLEN-1:0] ld_shifted, ld_ext;
    logic            misalign_out;

    assign ld_shifted = bus.i_dc_rdata >> {addr_q[2:0], 3'b000};

    riscv_core_ldextend u_ldextend (
        .i_data      (ld_shifted),
        .i_size      (size_q),
        .i_su_extend (su_q),
        .o_data      (ld_ext)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        su_d       = su_q;
        kill_d     = kill_q;
        size_d     = size_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        ready_d    = ready_q;
        dc_req_d   = dc_req_q;
        dc_we_d    = dc_we_q;
        dc_addr_d  = dc_addr_q;
        dc_wdata_d = dc_wdata_q;
        dc_be_d    = dc_be_q;
        done_d     = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        badaddr_d  = badaddr_q;
        misalign_d = 1'b0;
        exc_st_d   = exc_st_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_lsu_valid && !bus.i_lsu_kill) begin
                    we_d    = bus.i_lsu_we;
                    su_d    = bus.i_lsu_su_extend;
                    size_d  = bus.i_lsu_size;
                    addr_d  = bus.i_lsu_addr;
                    rd_d    = bus.i_lsu_rd;
                    kill_d  = 1'b0;
                    ready_d = 1'b0;
                    if (misaligned(bus.i_lsu_size, bus.i_lsu_addr[2:0])) begin
                        state_d    = ST_EXC;
                        misalign_d = 1'b1;
                        exc_st_d   = bus.i_lsu_we;
                        badaddr_d  = bus.i_lsu_addr;
                    end else begin
                        state_d    = ST_REQ;
                        dc_req_d   = 1'b1;
                        dc_we_d    = bus.i_lsu_we;
                        dc_addr_d  = {bus.i_lsu_addr[XLEN-1:3], 3'b000};
                        dc_be_d    = be_base(bus.i_lsu_size) << bus.i_lsu_addr[2:0];
                        dc_wdata_d = bus.i_lsu_wdata << {bus.i_lsu_addr[2:0], 3'b000};
                    end
                end
            end
            ST_REQ: begin
                if (bus.i_lsu_kill) kill_d = 1'b1;
                // The cache handshake must complete even for a squashed op.
                if (bus.i_dc_ack) begin
                    dc_req_d = 1'b0;
                    dc_we_d  = 1'b0;
                    if (kill_q || bus.i_lsu_kill) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        wb_valid_d = ~we_q;
                        wb_rd_d    = rd_q;
                        if (!we_q) wb_data_d = ld_ext;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            su_q       <= 1'b0;
            kill_q     <= 1'b0;
            size_q     <= SIZE_B;
            addr_q     <= '0;
            rd_q       <= '0;
            ready_q    <= 1'b1;
            dc_req_q   <= 1'b0;
            dc_we_q    <= 1'b0;
            dc_addr_q  <= '0;
            dc_wdata_q <= '0;
            dc_be_q    <= '0;
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            badaddr_q  <= '0;
            misalign_q <= 1'b0;
            exc_st_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            su_q       <= su_d;
            kill_q     <= kill_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            ready_q    <= ready_d;
            dc_req_q   <= dc_req_d;
            dc_we_q    <= dc_we_d;
            dc_addr_q  <= dc_addr_d;
            dc_wdata_q <= dc_wdata_d;
            dc_be_q    <= dc_be_d;
            done_q     <= done_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            badaddr_q  <= badaddr_d;
            misalign_q <= misalign_d;
            exc_st_q   <= exc_st_d;
        end
    end

    // A kill arriving while the exception is presented still squashes it.
    assign misalign_out = misalign_q & ~bus.i_lsu_kill;

    assign bus.o_lsu_ready    = ready_q;
    assign bus.o_lsu_stall    = bus.i_lsu_valid & ~done_q & ~misalign_out;
    assign bus.o_dc_req       = dc_req_q;
    assign bus.o_dc_we        = dc_we_q;
    assign bus.o_dc_addr      = dc_addr_q;
    assign bus.o_dc_be        = dc_be_q;
    assign bus.o_dc_wdata     = dc_wdata_q;
    assign bus.o_lsu_done     = done_q;
    assign bus.o_lsu_wb_valid = wb_valid_q;
    assign bus.o_lsu_wb_rd    = wb_rd_q;
    assign bus.o_lsu_wb_data  = wb_data_q;
    assign bus.o_lsu_misalign = misalign_out;
    assign bus.o_lsu_exc_st   = exc_st_q;
    assign bus.o_lsu_badaddr  = badaddr_q;
endmodule

// File: tb/tb_riscv_core_lsu_ctrl.sv
// tb/tb_riscv_core_lsu_ctrl.sv - directed self-checking bench for riscv_core_lsu_ctrl
module tb_riscv_core_lsu_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_core_lsu_ctrl_if bus ();

    riscv_core_lsu_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        we;
        logic        mis;
        logic        killed;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] wb;
        logic [63:0] badaddr;
        logic [4:0]  rd;
    } exp_t;

    exp_t        m_exp;
    bit          cur_valid = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] cap_wb, cap_wdata, cap_addr, cap_bad;
    logic [7:0]  cap_be;
    logic        cap_exc_st;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_be(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] t;
        t = ((16'd1 << (32'd1 << size)) - 16'd1) << off;
        return t[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [1:0] size, input logic su);
        int          nb;
        logic [63:0] v, mask;
        nb = 1 << size;
        v  = raw >> (8 * off);
        if (nb == 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & mask;
        if (!su && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Model built from the op description alone; drives the op after the next falling edge.
    task automatic start_op(input logic we, input logic [1:0] size, input logic su,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [4:0] rd, input logic [63:0] rdata);
        m_exp.we      = we;
        m_exp.mis     = (addr % (64'd1 << size)) != 0;
        m_exp.killed  = 1'b0;
        m_exp.addr    = {addr[63:3], 3'b000};
        m_exp.be      = m_be(size, addr[2:0]);
        m_exp.wdata   = wdata << (8 * addr[2:0]);
        m_exp.wb      = m_load(rdata, addr[2:0], size, su);
        m_exp.badaddr = addr;
        m_exp.rd      = rd;
        @(negedge clk); #1;
        chk("accept_ready", bus.o_lsu_ready, 1);
        bus.i_lsu_valid     = 1'b1;
        bus.i_lsu_we        = we;
        bus.i_lsu_size      = size;
        bus.i_lsu_su_extend = su;
        bus.i_lsu_addr      = addr;
        bus.i_lsu_wdata     = wdata;
        bus.i_lsu_rd        = rd;
        bus.i_dc_rdata      = rdata;
        cur_valid           = 1;
    endtask

    task automatic do_op(input logic we, input logic [1:0] size, input logic su,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                         input logic [63:0] rdata, input int delay, input int kill_at,
                         input int exp_lat);
        int reqcnt = 0;
        bit acked  = 0;
        bit fin    = 0;
        start_op(we, size, su, addr, wdata, rd, rdata);
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(negedge clk); #1;
            bus.i_dc_ack   = 1'b0;
            bus.i_lsu_kill = 1'b0;
            if (acked && m_exp.killed) begin
                chk("kill_ready_after_ack", bus.o_lsu_ready, 1);
                chk("kill_no_done", bus.o_lsu_done, 0);
                chk("kill_req_dropped", bus.o_dc_req, 0);
                fin = 1;
            end else if (bus.o_lsu_done || bus.o_lsu_misalign) begin
                chk("latency", cyc, exp_lat);
                cap_wb     = bus.o_lsu_wb_data;
                cap_exc_st = bus.o_lsu_exc_st;
                cap_bad    = bus.o_lsu_badaddr;
                fin        = 1;
            end else if (acked) begin
                chk("req_held_until_ack", 0, 1);
                fin = 1;
            end else if (bus.o_dc_req) begin
                reqcnt++;
                cap_be    = bus.o_dc_be;
                cap_wdata = bus.o_dc_wdata;
                cap_addr  = bus.o_dc_addr;
                if (reqcnt == kill_at) begin
                    bus.i_lsu_kill = 1'b1;
                    m_exp.killed   = 1'b1;
                end
                if (reqcnt == delay + 1) begin
                    bus.i_dc_ack = 1'b1;
                    acked        = 1;
                end
            end
        end
        if (!fin) chk("op_timeout", 0, 1);
        bus.i_lsu_valid = 1'b0;
        bus.i_dc_ack    = 1'b0;
        bus.i_lsu_kill  = 1'b0;
        cur_valid       = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall", bus.o_lsu_stall,
                bus.i_lsu_valid & ~bus.o_lsu_done & ~bus.o_lsu_misalign);
            if (bus.o_dc_req) begin
                chk("req_expected", cur_valid && !m_exp.mis, 1);
                chk("dc_addr", bus.o_dc_addr, m_exp.addr);
                chk("dc_be", bus.o_dc_be, m_exp.be);
                chk("dc_we", bus.o_dc_we, m_exp.we);
                if (m_exp.we) chk("dc_wdata", bus.o_dc_wdata, m_exp.wdata);
            end
            if (bus.o_lsu_done) begin
                chk("done_expected", cur_valid && !m_exp.mis && !m_exp.killed, 1);
                chk("wb_valid", bus.o_lsu_wb_valid, !m_exp.we);
                if (!m_exp.we) begin
                    chk("wb_rd", bus.o_lsu_wb_rd, m_exp.rd);
                    chk("wb_data", bus.o_lsu_wb_data, m_exp.wb);
                end
            end else begin
                chk("wb_valid_without_done", bus.o_lsu_wb_valid, 0);
            end
            if (bus.o_lsu_misalign) begin
                chk("misalign_expected", cur_valid && m_exp.mis, 1);
                chk("exc_st", bus.o_lsu_exc_st, m_exp.we);
                chk("badaddr", bus.o_lsu_badaddr, m_exp.badaddr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.i_lsu_valid = 0; bus.i_lsu_we = 0; bus.i_lsu_size = 0; bus.i_lsu_su_extend = 0;
        bus.i_lsu_addr = 0; bus.i_lsu_wdata = 0; bus.i_lsu_rd = 0; bus.i_lsu_kill = 0;
        bus.i_dc_ack = 0; bus.i_dc_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.o_lsu_ready, 1);
        chk("rst_req", bus.o_dc_req, 0);
        chk("rst_dc_we", bus.o_dc_we, 0);
        chk("rst_done", bus.o_lsu_done, 0);
        chk("rst_wb_valid", bus.o_lsu_wb_valid, 0);
        chk("rst_misalign", bus.o_lsu_misalign, 0);
        chk("rst_exc_st", bus.o_lsu_exc_st, 0);
        chk("rst_buses", bus.o_dc_addr | bus.o_dc_wdata | bus.o_lsu_wb_data | bus.o_lsu_badaddr, 0);
        chk("rst_be", bus.o_dc_be, 0);
        rst_n = 1'b1;

        do_op(0, 2'b00, 0, 64'h1003, 0, 5'd3, 64'h0000_0000_8000_0000, 0, 0, 2);
        chk("lb_wb_literal", cap_wb, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(0, 2'b01, 1, 64'h2006, 0, 5'd7, 64'hBEEF_0000_0000_0000, 0, 0, 2);
        chk("lhu_wb_literal", cap_wb, 64'h0000_0000_0000_BEEF);
        do_op(1, 2'b10, 0, 64'h3004, 64'hDEADBEEF, 5'd0, 0, 0, 0, 2);
        chk("sw_be_literal", cap_be, 8'hF0);
        chk("sw_wdata_literal", cap_wdata, 64'hDEADBEEF_0000_0000);
        chk("sw_addr_literal", cap_addr, 64'h3000);
        do_op(0, 2'b11, 0, 64'h4004, 0, 5'd9, 0, 0, 0, 1);
        chk("ld_exc_st_literal", cap_exc_st, 0);
        chk("ld_badaddr_literal", cap_bad, 64'h4004);
        do_op(1, 2'b01, 0, 64'h5001, 64'h1234, 5'd0, 0, 0, 0, 1);
        chk("sh_exc_st_literal", cap_exc_st, 1);
        do_op(0, 2'b10, 0, 64'h6004, 0, 5'd12, 64'h8000_0001_0000_0000, 2, 0, 4);
        chk("lw_wb_literal", cap_wb, 64'hFFFF_FFFF_8000_0001);
        do_op(1, 2'b11, 0, 64'h7000, 64'h0123_4567_89AB_CDEF, 5'd0, 0, 1, 0, 3);
        do_op(0, 2'b00, 1, 64'h8007, 0, 5'd31, 64'hF000_0000_0000_0000, 0, 0, 2);
        chk("lbu_wb_literal", cap_wb, 64'h0000_0000_0000_00F0);
        do_op(0, 2'b10, 0, 64'h9008, 0, 5'd4, 64'h1111_2222_3333_4444, 5, 2, 0);

        // Kill in IDLE on a misaligned op: neither a request nor an exception may follow.
        @(negedge clk); #1;
        bus.i_lsu_valid = 1'b1; bus.i_lsu_kill = 1'b1;
        bus.i_lsu_we = 1'b0; bus.i_lsu_size = 2'b10; bus.i_lsu_addr = 64'hA001;
        @(negedge clk); #1;
        chk("idle_kill_no_req", bus.o_dc_req, 0);
        chk("idle_kill_no_misalign", bus.o_lsu_misalign, 0);
        chk("idle_kill_ready", bus.o_lsu_ready, 1);
        bus.i_lsu_valid = 1'b0; bus.i_lsu_kill = 1'b0;

        // Reset while the cache request is outstanding, then a stray ack.
        start_op(0, 2'b10, 0, 64'hB000, 0, 5'd5, 64'h55);
        @(negedge clk); #1;
        chk("pre_rst_req", bus.o_dc_req, 1);
        rst_n = 1'b0; bus.i_lsu_valid = 1'b0; cur_valid = 0;
        @(negedge clk); #1;
        chk("rst_mid_req_dropped", bus.o_dc_req, 0);
        chk("rst_mid_ready", bus.o_lsu_ready, 1);
        rst_n = 1'b1; bus.i_dc_ack = 1'b1;
        @(negedge clk); #1;
        bus.i_dc_ack = 1'b0;
        chk("stray_ack_no_done", bus.o_lsu_done, 0);
        @(negedge clk); #1;
        chk("stray_ack_no_done_2", bus.o_lsu_done, 0);
        chk("stray_ack_ready", bus.o_lsu_ready, 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
